dual_issue_regfile: RTL and testbench



---
 rtl/dual_issue_regfile_if.sv | 34 +++
 rtl/dual_issue_regfile.sv | 67 ++++++
 tb/tb_dual_issue_regfile.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_regfile_if.sv
// Register-file port bundle: two writeback write ports and four decode read ports.
// There is no valid/ready handshake here. Writes are qualified only by wenK on the
// rising clock edge. Reads are pure combinational lookups. The register file never
// backpressures.
interface dual_issue_regfile_if #(
  parameter int DATA_W = 32
);
  logic              wen1;
  logic [4:0]        waddr1;
  logic [DATA_W-1:0] wdata1;
  logic              wen2;
  logic [4:0]        waddr2;
  logic [DATA_W-1:0] wdata2;
  logic [4:0]        raddr1;
  logic [4:0]        raddr2;
  logic [4:0]        raddr3;
  logic [4:0]        raddr4;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] rdata3;
  logic [DATA_W-1:0] rdata4;

  modport master (
    output wen1, waddr1, wdata1, wen2, waddr2, wdata2,
    output raddr1, raddr2, raddr3, raddr4,
    input  rdata1, rdata2, rdata3, rdata4
  );

  modport slave (
    input  wen1, waddr1, wdata1, wen2, waddr2, wdata2,
    input  raddr1, raddr2, raddr3, raddr4,
    output rdata1, rdata2, rdata3, rdata4
  );
endinterface

// File: rtl/dual_issue_regfile.sv
// 32-entry MIPS GPR file for the dual-issue core: four async read ports and two
// writeback write ports. Slot 2 is the younger instruction and wins on a write
// collision. With WB_BYPASS set, a same-cycle write is forwarded to the readers,
// so the ID forwarding muxes only have to cover EX/MEM results.
module dual_issue_regfile #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst,
  dual_issue_regfile_if.slave rf
);

  // Entry 0 is hardwired to zero, so it has no storage.
  logic [DATA_W-1:0] regs [1:NREG-1];
  // Read-side view of the file, with a constant zero at index 0.
  logic [DATA_W-1:0] view [0:NREG-1];
  logic [4:0]        ra   [4];
  logic [DATA_W-1:0] rd   [4];

  assign ra[0] = rf.raddr1;
  assign ra[1] = rf.raddr2;
  assign ra[2] = rf.raddr3;
  assign ra[3] = rf.raddr4;

  assign rf.rdata1 = rd[0];
  assign rf.rdata2 = rd[1];
  assign rf.rdata3 = rd[2];
  assign rf.rdata4 = rd[3];

  // Writeback. Slot 2 is tested first so the younger instruction wins a collision.
  // Each entry is gated by its enable, so an X address with wen low cannot write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (rf.wen2 && (rf.waddr2 == 5'(i)))      regs[i] <= rf.wdata2;
        else if (rf.wen1 && (rf.waddr1 == 5'(i))) regs[i] <= rf.wdata1;
      end
    end
  end

  assign view[0] = '0;
  generate
    for (genvar g = 1; g < NREG; g++) begin : g_view
      assign view[g] = regs[g];
    end
  endgenerate

  // Read ports. While in reset every port reads 0. Address 0 always reads 0.
  // Otherwise an optional writeback bypass applies, with slot 2 ahead of slot 1.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd[p] = '0;
      if (!rst && (ra[p] != 5'd0)) begin
        rd[p] = view[ra[p]];
        if (WB_BYPASS != 0) begin
          if (rf.wen2 && (rf.waddr2 == ra[p]))      rd[p] = rf.wdata2;
          else if (rf.wen1 && (rf.waddr1 == ra[p])) rd[p] = rf.wdata1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_regfile.sv
// Bench for dual_issue_regfile. It runs a bypass and a non-bypass instance side by
// side from the same stimulus.
module tb_dual_issue_regfile;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        wen1, wen2;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2;
  logic [4:0]  raddr [4];
  logic [31:0] rd_b  [4];
  logic [31:0] rd_n  [4];

  dual_issue_regfile_if #(.DATA_W(32)) if_b ();
  dual_issue_regfile_if #(.DATA_W(32)) if_n ();

  assign if_b.wen1 = wen1;  assign if_b.waddr1 = waddr1;  assign if_b.wdata1 = wdata1;
  assign if_b.wen2 = wen2;  assign if_b.waddr2 = waddr2;  assign if_b.wdata2 = wdata2;
  assign if_b.raddr1 = raddr[0];  assign if_b.raddr2 = raddr[1];
  assign if_b.raddr3 = raddr[2];  assign if_b.raddr4 = raddr[3];
  assign if_n.wen1 = wen1;  assign if_n.waddr1 = waddr1;  assign if_n.wdata1 = wdata1;
  assign if_n.wen2 = wen2;  assign if_n.waddr2 = waddr2;  assign if_n.wdata2 = wdata2;
  assign if_n.raddr1 = raddr[0];  assign if_n.raddr2 = raddr[1];
  assign if_n.raddr3 = raddr[2];  assign if_n.raddr4 = raddr[3];

  assign rd_b[0] = if_b.rdata1;  assign rd_b[1] = if_b.rdata2;
  assign rd_b[2] = if_b.rdata3;  assign rd_b[3] = if_b.rdata4;
  assign rd_n[0] = if_n.rdata1;  assign rd_n[1] = if_n.rdata2;
  assign rd_n[2] = if_n.rdata3;  assign rd_n[3] = if_n.rdata4;

  dual_issue_regfile #(.DATA_W(32), .NREG(32), .WB_BYPASS(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .rf  (if_b)
  );

  dual_issue_regfile #(.DATA_W(32), .NREG(32), .WB_BYPASS(0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .rf  (if_n)
  );

  // ---------------- reference model / scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Architectural read: r0 is 0. With bypass, an in-flight write is visible,
  // and the younger slot (slot 2) takes priority.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wen2 && waddr2 == a) return wdata2;
    if (byp && wen1 && waddr1 == a) return wdata1;
    return mdl[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    wen1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
    wen2 = 1'b0; waddr2 = 5'd0; wdata2 = 32'h0;
    for (int p = 0; p < 4; p++) raddr[p] = 5'd0;
  endtask

  // One clock edge. The model commits in program order, so slot 2 overwrites slot 1.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (wen1 && waddr1 != 5'd0) mdl[waddr1] = wdata1;
      if (wen2 && waddr2 != 5'd0) mdl[waddr2] = wdata2;
    end
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic            w1e;
    logic [4:0]      w1a;
    logic [31:0]     w1d;
    logic            w2e;
    logic [4:0]      w2a;
    logic [31:0]     w2d;
    logic [3:0][4:0]  ra;   // {port4, port3, port2, port1}
    logic [3:0][31:0] eb;   // expected read data with bypass
    logic [3:0][31:0] enb;  // expected read data without bypass
  } vec_t;

  vec_t tv [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    tv[0]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[2]  = '{1'b1, 5'd5, 32'h12345678, 1'b1, 5'd6, 32'h9ABCDEF0,
               {5'd6, 5'd0, 5'd0, 5'd5}, {32'h9ABCDEF0, 32'h0, 32'h0, 32'h12345678},
               {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               {5'd6, 5'd0, 5'd0, 5'd5}, {32'h9ABCDEF0, 32'h0, 32'h0, 32'h12345678},
               {32'h9ABCDEF0, 32'h0, 32'h0, 32'h12345678}};
    tv[4]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222,
               {5'd0, 5'd0, 5'd7, 5'd0}, {32'h0, 32'h0, 32'h22222222, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd7, 5'd7, 5'd0}, {32'h0, 32'h22222222, 32'h22222222, 32'h0},
               {32'h0, 32'h22222222, 32'h22222222, 32'h0}};
    tv[6]  = '{1'b1, 5'd9, 32'hAAAA0000, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd9, 5'd0, 5'd0}, {32'h0, 32'hAAAA0000, 32'h0, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[7]  = '{1'b1, 5'd9, 32'h0000BBBB, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd0, 5'd9, 5'd0}, {32'h0, 32'h0, 32'h0000BBBB, 32'h0},
               {32'h0, 32'h0, 32'hAAAA0000, 32'h0}};
    tv[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               {5'd0, 5'd0, 5'd9, 5'd5}, {32'h0, 32'h0, 32'h0000BBBB, 32'h12345678},
               {32'h0, 32'h0, 32'h0000BBBB, 32'h12345678}};
    tv[9]  = '{1'b1, 5'd3, 32'h00000003, 1'b1, 5'd0, 32'hFFFFFFFF,
               {5'd0, 5'd0, 5'd3, 5'd0}, {32'h0, 32'h0, 32'h00000003, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h0}};
    tv[10] = '{1'b0, 5'd10, 32'h5A5A5A5A, 1'b0, 5'd10, 32'hA5A5A5A5,
               {5'd0, 5'd3, 5'd0, 5'd10}, {32'h0, 32'h00000003, 32'h0, 32'h0},
               {32'h0, 32'h00000003, 32'h0, 32'h0}};

    // ---- reset with writes active: all reads 0, writes lost ----
    idle();
    rst = 1'b1;
    wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hCAFEF00D;
    wen2 = 1'b1; waddr2 = 5'd8; wdata2 = 32'h0BADC0DE;
    raddr[0] = 5'd4; raddr[1] = 5'd8; raddr[2] = 5'd4; raddr[3] = 5'd8;
    #2;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_b%0d", p), rd_b[p], 32'h0);
      chk($sformatf("rst_n%0d", p), rd_n[p], 32'h0);
    end
    tick();
    for (int p = 0; p < 4; p++) chk($sformatf("rst_edge_b%0d", p), rd_b[p], 32'h0);
    wen1 = 1'b0; wen2 = 1'b0;
    rst = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("post_rst_b%0d", p), rd_b[p], 32'h0);
      chk($sformatf("post_rst_n%0d", p), rd_n[p], 32'h0);
    end
    tick();

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 11; i++) begin
      wen1 = tv[i].w1e; waddr1 = tv[i].w1a; wdata1 = tv[i].w1d;
      wen2 = tv[i].w2e; waddr2 = tv[i].w2a; wdata2 = tv[i].w2d;
      for (int p = 0; p < 4; p++) raddr[p] = tv[i].ra[p];
      #4;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("vec%0d_b%0d", i, p), rd_b[p], tv[i].eb[p]);
        chk($sformatf("vec%0d_n%0d", i, p), rd_n[p], tv[i].enb[p]);
      end
      tick();
    end

    // ---- populate r1..r31 with their index, then async reset between edges ----
    idle();
    for (int k = 1; k < 32; k += 2) begin
      wen1 = 1'b1; waddr1 = 5'(k); wdata1 = 32'(k);
      wen2 = (k + 1 < 32); waddr2 = 5'(k + 1); wdata2 = 32'(k + 1);
      tick();
    end
    idle();
    for (int b = 1; b < 32; b += 4) begin
      for (int p = 0; p < 4; p++) raddr[p] = 5'((b + p) % 32);
      #1;
      for (int p = 0; p < 4; p++)
        chk($sformatf("fill_r%0d", (b + p) % 32), rd_n[p], 32'((b + p) % 32));
    end
    tick();
    raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd17; raddr[3] = 5'd31;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("midrst_b%0d", p), rd_b[p], 32'h0);
      chk($sformatf("midrst_n%0d", p), rd_n[p], 32'h0);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int b = 1; b < 32; b += 4) begin
      for (int p = 0; p < 4; p++) raddr[p] = 5'((b + p) % 32);
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("cleared_b_r%0d", (b + p) % 32), rd_b[p], 32'h0);
        chk($sformatf("cleared_n_r%0d", (b + p) % 32), rd_n[p], 32'h0);
      end
    end
    tick();

    // ---- random regression against the model ----
    for (int c = 0; c < 10000; c++) begin
      wen1 = 1'($urandom_range(0, 1)); waddr1 = 5'($urandom_range(0, 31)); wdata1 = $urandom;
      wen2 = 1'($urandom_range(0, 1)); waddr2 = 5'($urandom_range(0, 31)); wdata2 = $urandom;
      if ($urandom_range(0, 7) == 0) waddr2 = waddr1;
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 3))
          0:       raddr[p] = waddr1;
          1:       raddr[p] = waddr2;
          default: raddr[p] = 5'($urandom_range(0, 31));
        endcase
      end
      #4;
      for (int p = 0; p < 4; p++) exp_q.push_back(ref_read(raddr[p], 1'b1));
      for (int p = 0; p < 4; p++) exp_q.push_back(ref_read(raddr[p], 1'b0));
      for (int p = 0; p < 4; p++) chk($sformatf("rand%0d_b%0d", c, p), rd_b[p], exp_q.pop_front());
      for (int p = 0; p < 4; p++) chk($sformatf("rand%0d_n%0d", c, p), rd_n[p], exp_q.pop_front());
      tick();
    end

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
